seq_loader: RTL

- Writer side of the sequence-RAM interface that the alignment datapath reads during matrix filling and traceback.
- Accepts two ASCII nucleotide streams over a valid/ready handshake: sequence A first, then sequence B.
- Encodes each character to the 3-bit symbol code and writes it into the A or B sequence RAM at addresses 1..len. Address 0 is never written; it is the gap row/column.
- Reports both lengths and raises `loaded` so the control FSM can start initialisation.

---
 rtl/seq_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_loader.sv
// Sequence loader: encodes two ASCII nucleotide streams (A then B) into 3-bit
// symbols and writes them at addresses 1..len. Define LOADER_LOWERCASE_EN to accept lowercase bases.
module seq_loader #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             in_ready,
    output logic             weA,
    output logic             weB,
    output logic [BitAddr:0] addr,
    output logic [2:0]       din,
    output logic [BitAddr:0] lenA,
    output logic [BitAddr:0] lenB,
    output logic             loaded,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        DONE,
        ERR
    } state_t;

    localparam logic [BitAddr:0] CNT_ONE = (BitAddr + 1)'(1);
    localparam logic [BitAddr:0] CNT_MAX = (BitAddr + 1)'(N);

    state_t           state, state_nxt;
    logic [BitAddr:0] cnt, cnt_nxt;
    logic [BitAddr:0] addr_nxt, len_a_nxt, len_b_nxt;
    logic [2:0]       din_nxt;
    logic             we_a_nxt, we_b_nxt;
    logic             xfer;
    logic [7:0]       folded;
    logic [2:0]       code;
    logic             code_ok;

    assign xfer = in_valid & in_ready;

`ifdef LOADER_LOWERCASE_EN
    assign folded = (in_char >= 8'h61 && in_char <= 8'h7a) ? in_char - 8'h20 : in_char;
`else
    assign folded = in_char;
`endif

    always_comb begin
        code    = 3'b000;
        code_ok = 1'b0;
        case (folded)
            8'h41: begin code = 3'b000; code_ok = 1'b1; end
            8'h43: begin code = 3'b001; code_ok = 1'b1; end
            8'h47: begin code = 3'b010; code_ok = 1'b1; end
            8'h54: begin code = 3'b011; code_ok = 1'b1; end
            default: begin code = 3'b000; code_ok = 1'b0; end
        endcase
    end

    // Outputs are computed one cycle ahead here and registered below, which
    // gives the one-cycle write latency and a state-only in_ready.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr;
        din_nxt   = din;
        len_a_nxt = lenA;
        len_b_nxt = lenB;
        we_a_nxt  = 1'b0;
        we_b_nxt  = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = LOAD_A;
                    cnt_nxt   = CNT_ONE;
                end
            end
            LOAD_A, LOAD_B: begin
                if (xfer) begin
                    if (!code_ok) begin
                        state_nxt = ERR;
                    end else begin
                        we_a_nxt = (state == LOAD_A);
                        we_b_nxt = (state == LOAD_B);
                        addr_nxt = cnt;
                        din_nxt  = code;
                        if (in_last) begin
                            if (state == LOAD_A) begin
                                len_a_nxt = cnt;
                                cnt_nxt   = CNT_ONE;
                                state_nxt = LOAD_B;
                            end else begin
                                len_b_nxt = cnt;
                                state_nxt = DONE;
                            end
                        end else if (cnt == CNT_MAX) begin
                            state_nxt = ERR;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
            weA      <= 1'b0;
            weB      <= 1'b0;
            addr     <= '0;
            din      <= '0;
            lenA     <= '0;
            lenB     <= '0;
            loaded   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            in_ready <= (state_nxt == LOAD_A) || (state_nxt == LOAD_B);
            weA      <= we_a_nxt;
            weB      <= we_b_nxt;
            addr     <= addr_nxt;
            din      <= din_nxt;
            lenA     <= len_a_nxt;
            lenB     <= len_b_nxt;
            loaded   <= (state_nxt == DONE);
            err      <= (state_nxt == ERR);
        end
    end

endmodule
